// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - multi-cycle multiply/divide unit with HI/LO and hazard stall
// Optional MDU_DIVZERO_SKIP_EN: divide by zero skips RUN and leaves HI/LO untouched.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        req_md,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic [0:0]    state;
  logic [CW-1:0] cnt;
  logic [31:0]   a_q, b_q;
  logic [2:0]    op_q;

  logic        is_md_op, is_div_op, start_md, enter_run;
  logic [63:0] prod_s, prod_u;
  logic [31:0] quo_s, rem_s, quo_u, rem_u;
  logic [31:0] res_hi, res_lo;

  assign is_md_op  = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  assign is_div_op = (op == OP_DIV) || (op == OP_DIVU);
  assign start_md  = start && (state == IDLE) && is_md_op;

`ifdef MDU_DIVZERO_SKIP_EN
  assign enter_run = start_md && !(is_div_op && (B == 32'd0));
`else
  assign enter_run = start_md;
`endif

  assign busy  = (state == RUN);
  assign stall = req_md && (busy || start_md);

  // Operands are sign- or zero-extended to 64 bits so the product keeps its full width.
  assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};
  assign quo_s  = $signed(a_q) / $signed(b_q);
  assign rem_s  = $signed(a_q) % $signed(b_q);
  assign quo_u  = a_q / b_q;
  assign rem_u  = a_q % b_q;

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (op_q)
      OP_MULT:  begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
      OP_MULTU: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
      OP_DIV, OP_DIVU: begin
        if (b_q == 32'd0) begin
          res_hi = a_q;
          res_lo = 32'hFFFF_FFFF;
        end else if (op_q == OP_DIV) begin
          res_hi = rem_s;
          res_lo = quo_s;
        end else begin
          res_hi = rem_u;
          res_lo = quo_u;
        end
      end
      default: begin res_hi = 32'd0; res_lo = 32'd0; end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      op_q  <= 3'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
    end else if (state == IDLE) begin
      if (enter_run) begin
        a_q   <= A;
        b_q   <= B;
        op_q  <= op;
        cnt   <= is_div_op ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        state <= RUN;
      end else if (start && (op == OP_MTHI)) begin
        hi <= A;
      end else if (start && (op == OP_MTLO)) begin
        lo <= A;
      end
    end else begin
      // Any start seen here is dropped; the hazard logic keeps it from happening.
      if (cnt == CW'(1)) begin
        hi    <= res_hi;
        lo    <= res_lo;
        cnt   <= '0;
        state <= IDLE;
      end else begin
        cnt <= cnt - CW'(1);
      end
    end
  end

endmodule
